uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter: DATA_W, 8, maximum data bits per frame (legal 5..9).
REQ-002 Parameter: OVS, 16, RX_clk cycles per bit (even, legal 8..32).
REQ-003 Port: RX_clk  input  1  oversampling clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: rx  input  1  serial line, idle high, asynchronous to RX_clk.
REQ-006 Port: data_len  input  4  data bits per frame; 5..DATA_W used as-is, <5 treated as 5, >DATA_W treated as DATA_W.
REQ-007 Port: par  input  2  parity mode: 00 odd, 11 even, 01/10 none.
REQ-008 Port: snum  input  1  stop bits: 0 = two, 1 = one.
REQ-009 Port: rx_data  output  DATA_W  received word, LSB-aligned, unused upper bits 0.
REQ-010 Port: rx_valid  output  1  rx_data/parity_err/frame_err valid.
REQ-011 Port: rx_ready  input  1  consumer accepts word when rx_valid && rx_ready.
REQ-012 Port: parity_err  output  1  parity mismatch for the word on rx_data.
REQ-013 Port: frame_err  output  1  a stop bit was sampled low for the word on rx_data.
REQ-014 Port: overrun  output  1  one-cycle pulse, completed frame dropped.
REQ-015 Port: busy  output  1  high in every FSM state except IDLE.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; every use of rx below refers to the synchronized value.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-018 IDLE: on a high-to-low transition of rx, FSM SHALL go to START, clear the bit counter, and latch data_len, par and snum for the whole frame.
REQ-019 START: after OVS/2 cycles, rx sampled high SHALL return FSM to IDLE (false start, no output); sampled low SHALL enter DATA.
REQ-020 Every later bit SHALL be sampled exactly OVS cycles after the previous sample point (mid-bit).
REQ-021 DATA SHALL shift bits in LSB first, then go to PARITY if parity is enabled, otherwise to STOP1.
REQ-022 PARITY SHALL set parity_err when XOR of the data bits and the parity bit is 0 (odd mode) or 1 (even mode).
REQ-023 STOP1 with snum=1, or STOP2, SHALL end the frame; STOP1 with snum=0 SHALL go to STOP2.
REQ-024 A low stop sample SHALL set frame_err, skip STOP2 and end the frame.
REQ-025 At frame end FSM SHALL return to IDLE, and on the next cycle rx_data, parity_err, frame_err and rx_valid=1 SHALL be registered (latency 1 cycle after the final stop sample).
REQ-026 rx_valid, rx_data and the error flags SHALL hold until the cycle after rx_valid && rx_ready.
REQ-027 If a frame ends while rx_valid=1 and rx_ready=0, the new word SHALL be dropped, the held word SHALL be unchanged, and overrun SHALL pulse for one cycle.
REQ-028 If a frame ends in the same cycle the held word is accepted, the new word SHALL load and rx_valid SHALL stay high with no overrun.
REQ-029 Input changes to data_len, par or snum during a frame SHALL NOT affect that frame.

Reset
REQ-030 While rst=1 at a clock edge: FSM SHALL go to IDLE, counters to 0, synchronizer flops to 1, and rx_data, rx_valid, parity_err, frame_err, overrun and busy to 0.
REQ-031 rst asserted mid-frame SHALL discard the partial frame with no output.

Configuration
REQ-032 With RX_MAJORITY_EN defined, each sample (start, data, parity, stop) SHALL be the 2-of-3 majority of rx at offsets -1, 0 and +1 cycle around the mid-bit point.
REQ-033 With RX_MAJORITY_EN undefined, each sample SHALL be the single value of rx at the mid-bit point, and no majority logic SHALL be synthesized.

Verification
REQ-034 DATA_W=8, OVS=16, data_len=8, par=11, snum=1, send 0xA5, rx_ready=1 -> rx_data=0xA5, parity_err=0, frame_err=0, rx_valid high for one cycle.
REQ-035 data_len=5, par=00, snum=0, send 0x13 with a wrong parity bit -> rx_data=0x13, parity_err=1.
REQ-036 Stop bit driven low, frame 0x3C -> rx_data=0x3C, frame_err=1; the next valid frame 0x55 is received clean.
REQ-037 rx_ready=0, send two frames 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once.
REQ-038 rx low for 4 cycles then high -> no rx_valid, busy back to 0 within OVS/2+3 cycles; with RX_MAJORITY_EN, a 1-cycle glitch at a data mid-bit does not change rx_data.
REQ-039 rst for 1 cycle during bit 3 of a frame -> all outputs 0, next frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: runtime data length, parity mode and stop-bit count, one-word holding register.
// Optional build macro RX_MAJORITY_EN: each sample becomes a 2-of-3 vote over three consecutive cycles.
module uart_rx_param #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              RX_clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [3:0]        data_len,
    input  logic [1:0]        par,
    input  logic              snum,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(OVS);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        if (l < 4'd5) begin
            return 4'd5;
        end else if (l > 4'(DATA_W)) begin
            return 4'(DATA_W);
        end else begin
            return l;
        end
    endfunction

    // Unused upper word bits are zero, so a full-width XOR is safe.
    function automatic logic parity_mismatch(input logic [DATA_W-1:0] d, input logic p, input logic odd);
        logic x;
        x = (^d) ^ p;
        return odd ? ~x : x;
    endfunction

    logic rx_s, fall_s, sample_s, tick_s;
    logic sync1_r, sync2_r, prev_r;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge RX_clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rx_s   = sync2_r;
    assign fall_s = prev_r & ~rx_s;

`ifdef RX_MAJORITY_EN
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] hist_r;

    // Two previous synchronized values, forming a three-cycle vote window with rx_s
    always_ff @(posedge RX_clk) begin
        if (rst) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rx_s};
        end
    end

    assign sample_s = majority3(hist_r[1], hist_r[0], rx_s);
`else
    assign sample_s = rx_s;
`endif

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s;
    logic [3:0]          bit_r, bit_next_s;
    logic [3:0]          len_r, len_next_s;
    logic [DATA_W-1:0]   shreg_r, shreg_next_s;
    logic                par_en_r, par_en_next_s;
    logic                par_odd_r, par_odd_next_s;
    logic                two_stop_r, two_stop_next_s;
    logic                perr_r, perr_next_s;
    logic                ferr_r, ferr_next_s;
    logic                done_r, done_next_s;

    assign tick_s = (state_r == START) ? (cnt_r == HALF_M1) : (cnt_r == FULL_M1);

    // Frame state, timing counters and the per-frame configuration snapshot
    always_ff @(posedge RX_clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            bit_r      <= 4'd0;
            len_r      <= 4'd0;
            shreg_r    <= {DATA_W{1'b0}};
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            two_stop_r <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            bit_r      <= bit_next_s;
            len_r      <= len_next_s;
            shreg_r    <= shreg_next_s;
            par_en_r   <= par_en_next_s;
            par_odd_r  <= par_odd_next_s;
            two_stop_r <= two_stop_next_s;
            perr_r     <= perr_next_s;
            ferr_r     <= ferr_next_s;
            done_r     <= done_next_s;
        end
    end

    // Next-state and datapath updates; every bit after start is sampled one full bit after the last
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = tick_s ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        bit_next_s      = bit_r;
        len_next_s      = len_r;
        shreg_next_s    = shreg_r;
        par_en_next_s   = par_en_r;
        par_odd_next_s  = par_odd_r;
        two_stop_next_s = two_stop_r;
        perr_next_s     = perr_r;
        ferr_next_s     = ferr_r;
        done_next_s     = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_next_s = {CNT_W{1'b0}};
                if (fall_s) begin
                    state_next_s    = START;
                    bit_next_s      = 4'd0;
                    shreg_next_s    = {DATA_W{1'b0}};
                    perr_next_s     = 1'b0;
                    ferr_next_s     = 1'b0;
                    len_next_s      = clamp_len(data_len);
                    par_en_next_s   = (par == 2'b00) || (par == 2'b11);
                    par_odd_next_s  = (par == 2'b00);
                    two_stop_next_s = ~snum;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_next_s = sample_s ? IDLE : DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_r == 4'(i)) begin
                            shreg_next_s[i] = sample_s;
                        end else begin
                            shreg_next_s[i] = shreg_r[i];
                        end
                    end
                    if (bit_r == len_r - 4'd1) begin
                        bit_next_s   = 4'd0;
                        state_next_s = par_en_r ? PARITY : STOP1;
                    end else begin
                        bit_next_s = bit_r + 4'd1;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    perr_next_s  = parity_mismatch(shreg_r, sample_s, par_odd_r);
                    state_next_s = STOP1;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP1: begin
                if (tick_s) begin
                    if (!sample_s) begin
                        ferr_next_s  = 1'b1;
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                    end else if (two_stop_r) begin
                        state_next_s = STOP2;
                    end else begin
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                    end
                end else begin
                    state_next_s = STOP1;
                end
            end
            STOP2: begin
                if (tick_s) begin
                    ferr_next_s  = ~sample_s;
                    state_next_s = IDLE;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = STOP2;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r, parity_err_r, frame_err_r, overrun_r, busy_r;

    // Holding register: a finished frame loads unless the previous word is still unaccepted
    always_ff @(posedge RX_clk) begin
        if (rst) begin
            rx_data_r    <= {DATA_W{1'b0}};
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            busy_r    <= (state_next_s != IDLE);
            if (done_r) begin
                if (!rx_valid_r || rx_ready) begin
                    rx_data_r    <= shreg_r;
                    parity_err_r <= perr_r;
                    frame_err_r  <= ferr_r;
                    rx_valid_r   <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed frames plus randomized frames against a word-level model.
module tb_uart_rx_param;

    localparam int DW  = 8;
    localparam int OVS = 16;

    logic          RX_clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic [3:0]    data_len = 4'd8;
    logic [1:0]    par = 2'b11;
    logic          snum = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid, parity_err, frame_err, overrun, busy;

    uart_rx_param #(.DATA_W(DW), .OVS(OVS)) dut (
        .RX_clk(RX_clk), .rst(rst), .rx(rx), .data_len(data_len), .par(par), .snum(snum),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 RX_clk = ~RX_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        int            nbits;
        int            start_cyc;
    } exp_t;

    exp_t          expq[$];
    int            checks = 0, errors = 0;
    int            cyc = 0, vcount = 0, ovr_seen = 0, exp_ovr = 0;
    bit            hold_mode = 1'b0, rand_ready = 1'b0;
    logic [DW-1:0] last_data = '0;
    logic          last_perr = 1'b0, last_ferr = 1'b0;

    always @(posedge RX_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge RX_clk);
            #1;
        end
    endtask

    // Compare process: every valid cycle against the head of the expected-word queue
    initial begin
        bit valid_prev, ovr_prev;
        int lat, lo;
        valid_prev = 1'b0;
        ovr_prev   = 1'b0;
        forever begin
            @(negedge RX_clk);
            if (rst !== 1'b0) begin
                valid_prev = 1'b0;
                ovr_prev   = 1'b0;
            end else begin
                if (overrun) begin
                    ovr_seen++;
                    check("overrun_one_cycle", 32'(ovr_prev), 32'd0);
                end
                ovr_prev = overrun;
                if (rx_valid) begin
                    vcount++;
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: rx_data 0x%0h, required no word", rx_data);
                    end else begin
                        check("rx_data", 32'(rx_data), 32'(expq[0].data));
                        check("parity_err", 32'(parity_err), 32'(expq[0].perr));
                        check("frame_err", 32'(frame_err), 32'(expq[0].ferr));
                        if (!valid_prev) begin
                            // final sample sits mid-bit; add synchronizer, edge detect and output register
                            lat = cyc - expq[0].start_cyc;
                            lo  = OVS * expq[0].nbits + OVS / 2 + 2;
                            checks++;
                            if (lat < lo || lat > lo + 4) begin
                                errors++;
                                $display("FAIL latency: got %0d cycles, required %0d..%0d", lat, lo, lo + 4);
                            end
                        end
                        if (rx_ready) begin
                            last_data = rx_data;
                            last_perr = parity_err;
                            last_ferr = frame_err;
                            void'(expq.pop_front());
                        end
                    end
                end
                valid_prev = rx_valid;
            end
        end
    end

    // Random consumer back-pressure during the randomized phase
    initial forever begin
        @(posedge RX_clk);
        #1;
        if (rand_ready) rx_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic drive_bit(input logic b, input bit glitch);
        rx = b;
        for (int c = 1; c <= OVS; c++) begin
            tick(1);
            rx = (glitch && c == OVS / 2) ? ~b : b;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] word, input logic [3:0] len_in, input logic [1:0] par_in,
                              input logic snum_in, input bit bad_par, input bit bad_stop,
                              input bit scramble, input int glitch_bit);
        int            eff;
        logic [DW-1:0] w;
        bit            pen, odd;
        logic          pb, x;
        exp_t          e;
        eff = (len_in < 4'd5) ? 5 : ((int'(len_in) > DW) ? DW : int'(len_in));
        w = '0;
        for (int i = 0; i < eff; i++) w[i] = word[i];
        pen = (par_in == 2'b00) || (par_in == 2'b11);
        odd = (par_in == 2'b00);
        pb  = (odd ? ~(^w) : (^w)) ^ bad_par;
        x   = (^w) ^ pb;
        e.data      = w;
        e.perr      = pen && (odd ? (x == 1'b0) : (x == 1'b1));
        e.ferr      = bad_stop;
        e.nbits     = eff + (pen ? 1 : 0) + (bad_stop ? 1 : (snum_in ? 1 : 2));
        e.start_cyc = cyc;
        data_len = len_in;
        par      = par_in;
        snum     = snum_in;
        if (hold_mode && expq.size() != 0) exp_ovr++;
        else expq.push_back(e);
        drive_bit(1'b0, 1'b0);
        if (scramble) begin
            data_len = 4'($urandom);
            par      = 2'($urandom);
            snum     = 1'($urandom);
        end
        for (int i = 0; i < eff; i++) drive_bit(w[i], i == glitch_bit);
        if (pen) drive_bit(pb, 1'b0);
        drive_bit(~bad_stop, 1'b0);
        if (!snum_in) drive_bit(1'b1, 1'b0);
        rx = 1'b1;
    endtask

    task automatic drain(input int limit);
        int t = 0;
        while (expq.size() != 0 && t < limit) begin
            tick(1);
            t++;
        end
        check("drain_timeout", 32'(expq.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_data"}, 32'(rx_data), 32'd0);
        check({tag, "_perr"}, 32'(parity_err), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int            v0, o0;
        bit            saw_busy;
        logic [DW-1:0] w7;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(5);

        // 0xA5, 8 bits, even parity, one stop
        rx_ready = 1'b1;
        v0 = vcount;
        send_frame(8'hA5, 4'd8, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        drain(40);
        check("a5_data", 32'(last_data), 32'h0000_00A5);
        check("a5_perr", 32'(last_perr), 32'd0);
        check("a5_ferr", 32'(last_ferr), 32'd0);
        check("a5_valid_cycles", 32'(vcount - v0), 32'd1);
        tick(10);

        // 5 bits, odd parity with a wrong parity bit, two stops
        send_frame(8'h13, 4'd5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        drain(40);
        check("13_data", 32'(last_data), 32'h0000_0013);
        check("13_perr", 32'(last_perr), 32'd1);
        tick(10);

        // low stop bit, then a clean frame
        send_frame(8'h3C, 4'd8, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        drain(40);
        check("3c_data", 32'(last_data), 32'h0000_003C);
        check("3c_ferr", 32'(last_ferr), 32'd1);
        tick(OVS);
        send_frame(8'h55, 4'd8, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        drain(40);
        check("55_data", 32'(last_data), 32'h0000_0055);
        check("55_ferr", 32'(last_ferr), 32'd0);
        check("55_perr", 32'(last_perr), 32'd0);
        tick(10);

        // consumer stalled: second word is dropped with one overrun pulse
        rx_ready  = 1'b0;
        hold_mode = 1'b1;
        o0 = ovr_seen;
        send_frame(8'h11, 4'd8, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        tick(8);
        send_frame(8'h22, 4'd8, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        tick(30);
        check("hold_valid", 32'(rx_valid), 32'd1);
        check("hold_data", 32'(rx_data), 32'h0000_0011);
        check("hold_overruns", 32'(ovr_seen - o0), 32'd1);
        hold_mode = 1'b0;
        rx_ready  = 1'b1;
        drain(10);
        check("hold_released", 32'(last_data), 32'h0000_0011);
        tick(10);

        // false start: 4 low cycles
        v0 = vcount;
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int i = 1; i <= OVS / 2 + 3; i++) begin
            tick(1);
            if (i == 4) rx = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        check("false_start_busy_seen", 32'(saw_busy), 32'd1);
        check("false_start_busy_end", 32'(busy), 32'd0);
        tick(3 * OVS);
        check("false_start_no_word", 32'(vcount - v0), 32'd0);

        // reset during bit 3 of a frame
        w7 = 8'h7E;
        data_len = 4'd8;
        par      = 2'b11;
        snum     = 1'b1;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(w7[i], 1'b0);
        rx = w7[3];
        tick(OVS / 2);
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        rst = 1'b0;
        check_all_zero("midrst");
        v0 = vcount;
        tick(12 * OVS);
        check("midrst_no_word", 32'(vcount - v0), 32'd0);
        send_frame(8'h7E, 4'd8, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        drain(40);
        check("7e_data", 32'(last_data), 32'h0000_007E);
        tick(10);

`ifdef RX_MAJORITY_EN
        send_frame(8'h5A, 4'd8, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        drain(40);
        check("glitch_data", 32'(last_data), 32'h0000_005A);
        tick(10);
`endif

        // randomized frames: lengths beyond both clamps, all parity modes, config changed mid-frame
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            send_frame(8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 1'b1, -1);
            tick($urandom_range(1, 20));
        end
        rand_ready = 1'b0;
        tick(1);
        rx_ready = 1'b1;
        drain(200);
        check("overrun_total", 32'(ovr_seen), 32'(exp_ovr));
        check("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
